// File: rtl/dcache_mshr_pkg.sv
//----------------------------------------------------------------------------
// Module : dcache_mshr_pkg
// Brief  : Shared types and constants for the D-cache miss-status holding regs.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

`ifndef DCACHE_MSHR_DEPTH
`define DCACHE_MSHR_DEPTH 4
`endif

package dcache_mshr_pkg;

  localparam int   c_dcache_mshr_depth = `DCACHE_MSHR_DEPTH;

  localparam logic c_mem_cmd_load  = 1'b0;
  localparam logic c_mem_cmd_store = 1'b1;

  typedef enum logic [1:0] {
    MSHR_FREE    = 2'd0,
    MSHR_PENDING = 2'd1,
    MSHR_ISSUED  = 2'd2
  } mshr_state_e;

  // Slot layout at the default block geometry (29-bit block addr, 64-bit block, 4-bit tag)
  typedef struct packed {
    mshr_state_e state;
    logic        cmd;
    logic [28:0] addr;
    logic [63:0] data;
    logic [3:0]  tag;
  } mshr_entry_t;

endpackage

`default_nettype wire

// File: rtl/dcache_mshr_idx_fifo.sv
//----------------------------------------------------------------------------
// Module : dcache_mshr_idx_fifo
// Brief  : Circular FIFO of MSHR slot indices, preserving request arrival order.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module dcache_mshr_idx_fifo #(
  parameter int DEPTH    = 4,
  parameter int IDX_BITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_push,
  input  logic [IDX_BITS-1:0] i_push_idx,
  input  logic                i_pop,
  output logic [IDX_BITS-1:0] o_head_idx,
  output logic                o_empty,
  output logic                o_full
);

  logic [IDX_BITS-1:0] r_mem [DEPTH];
  // Extra MSB on each pointer distinguishes full from empty after wrap-around
  logic [IDX_BITS:0]   r_wr_ptr;
  logic [IDX_BITS:0]   r_rd_ptr;
  logic                w_push;
  logic                w_pop;

  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[IDX_BITS] != r_rd_ptr[IDX_BITS]) &&
                      (r_wr_ptr[IDX_BITS-1:0] == r_rd_ptr[IDX_BITS-1:0]);
  assign o_head_idx = r_mem[r_rd_ptr[IDX_BITS-1:0]];
  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[IDX_BITS-1:0]] <= i_push_idx;
        r_wr_ptr                      <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dcache_mshr.sv
//----------------------------------------------------------------------------
// Module : dcache_mshr
// Brief  : D-cache MSHR: queues refills/writebacks in order, matches returns.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module dcache_mshr
  import dcache_mshr_pkg::*;
#(
  parameter int DEPTH         = c_dcache_mshr_depth,
  parameter int BLK_ADDR_BITS = 29,
  parameter int TAG_BITS      = 4,
  parameter int DATA_BITS     = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         miss_valid,
  input  logic                         miss_cmd,
  input  logic [BLK_ADDR_BITS-1:0]     miss_addr,
  input  logic [DATA_BITS-1:0]         miss_data,
  output logic                         miss_ready,
  output logic                         mem_req_valid,
  output logic                         mem_req_cmd,
  output logic [BLK_ADDR_BITS-1:0]     mem_req_addr,
  output logic [DATA_BITS-1:0]         mem_req_data,
  input  logic                         mem_req_accepted,
  input  logic [TAG_BITS-1:0]          current_req_tag,
  input  logic [TAG_BITS-1:0]          mem_data_tag,
  input  logic [DATA_BITS-1:0]         mem_data,
  output logic                         fill_valid,
  output logic [BLK_ADDR_BITS-1:0]     fill_addr,
  output logic [DATA_BITS-1:0]         fill_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int c_idx_bits = $clog2(DEPTH);
  localparam int c_occ_bits = $clog2(DEPTH+1);

  mshr_state_e              r_state [DEPTH];
  logic                     r_cmd   [DEPTH];
  logic [BLK_ADDR_BITS-1:0] r_addr  [DEPTH];
  logic [DATA_BITS-1:0]     r_data  [DEPTH];
  logic [TAG_BITS-1:0]      r_tag   [DEPTH];

  logic                     r_fill_valid;
  logic [BLK_ADDR_BITS-1:0] r_fill_addr;
  logic [DATA_BITS-1:0]     r_fill_data;

  logic [c_occ_bits-1:0]    w_occ;
  logic                     w_free_found;
  logic [c_idx_bits-1:0]    w_free_idx;
  logic                     w_merge;
  logic                     w_accept;
  logic                     w_alloc;
  logic                     w_ret_found;
  logic [c_idx_bits-1:0]    w_ret_idx;
  logic                     w_ret_hit;
  logic                     w_issue;
  logic [c_idx_bits-1:0]    w_head_idx;
  logic                     w_fifo_empty;
  logic                     w_fifo_full;

  // All selection below looks only at start-of-cycle slot state
  always_comb begin
    w_occ        = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_merge      = 1'b0;
    w_ret_found  = 1'b0;
    w_ret_idx    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_state[i] != MSHR_FREE) begin
        w_occ = w_occ + c_occ_bits'(1);
      end
      if (r_state[i] == MSHR_FREE) begin
        w_free_found = 1'b1;
        w_free_idx   = c_idx_bits'(i);
      end
      if ((r_state[i] != MSHR_FREE) && (r_cmd[i] == c_mem_cmd_load) &&
          (r_addr[i] == miss_addr)) begin
        w_merge = 1'b1;
      end
      if ((r_state[i] == MSHR_ISSUED) && (r_tag[i] == mem_data_tag)) begin
        w_ret_found = 1'b1;
        w_ret_idx   = c_idx_bits'(i);
      end
    end
  end

  assign miss_ready = (w_occ < c_occ_bits'(DEPTH));
  assign w_accept   = miss_valid && miss_ready;
  // Loads to an address already in flight ride on the existing fill
  assign w_alloc    = w_accept && !((miss_cmd == c_mem_cmd_load) && w_merge) &&
                      w_free_found && !w_fifo_full;
  assign w_ret_hit  = w_ret_found && (mem_data_tag != '0);
  assign w_issue    = mem_req_accepted && !w_fifo_empty;

  dcache_mshr_idx_fifo #(
    .DEPTH    (DEPTH),
    .IDX_BITS (c_idx_bits)
  ) u_idx_fifo (
    .clk        (clock),
    .rst_n      (reset),
    .i_push     (w_alloc),
    .i_push_idx (w_free_idx),
    .i_pop      (w_issue),
    .o_head_idx (w_head_idx),
    .o_empty    (w_fifo_empty),
    .o_full     (w_fifo_full)
  );

  assign mem_req_valid = !w_fifo_empty;
  assign mem_req_cmd   = w_fifo_empty ? 1'b0 : r_cmd[w_head_idx];
  assign mem_req_addr  = w_fifo_empty ? '0   : r_addr[w_head_idx];
  assign mem_req_data  = w_fifo_empty ? '0   : r_data[w_head_idx];

  // Allocate, issue and return target disjoint slots (FREE, PENDING, ISSUED)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i] <= MSHR_FREE;
        r_cmd[i]   <= 1'b0;
        r_addr[i]  <= '0;
        r_data[i]  <= '0;
        r_tag[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alloc && (w_free_idx == c_idx_bits'(i))) begin
          r_state[i] <= MSHR_PENDING;
          r_cmd[i]   <= miss_cmd;
          r_addr[i]  <= miss_addr;
          r_data[i]  <= miss_data;
          r_tag[i]   <= '0;
        end else if (w_issue && (w_head_idx == c_idx_bits'(i))) begin
          if (r_cmd[i] == c_mem_cmd_store) begin
            r_state[i] <= MSHR_FREE;
          end else begin
            r_state[i] <= MSHR_ISSUED;
            r_tag[i]   <= current_req_tag;
          end
        end else if (w_ret_hit && (w_ret_idx == c_idx_bits'(i))) begin
          r_state[i] <= MSHR_FREE;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fill_valid <= 1'b0;
      r_fill_addr  <= '0;
      r_fill_data  <= '0;
    end else begin
      r_fill_valid <= w_ret_hit;
      if (w_ret_hit) begin
        r_fill_addr <= r_addr[w_ret_idx];
        r_fill_data <= mem_data;
      end
    end
  end

  assign fill_valid = r_fill_valid;
  assign fill_addr  = r_fill_addr;
  assign fill_data  = r_fill_data;
  assign occupancy  = w_occ;

endmodule

`default_nettype wire

// File: tb/tb_dcache_mshr.sv
//----------------------------------------------------------------------------
// Module : tb_dcache_mshr
// Brief  : Scoreboard bench for dcache_mshr request ordering and fill matching.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_dcache_mshr;

  logic        clock;
  logic        reset;
  logic        miss_valid;
  logic        miss_cmd;
  logic [28:0] miss_addr;
  logic [63:0] miss_data;
  logic        miss_ready;
  logic        mem_req_valid;
  logic        mem_req_cmd;
  logic [28:0] mem_req_addr;
  logic [63:0] mem_req_data;
  logic        mem_req_accepted;
  logic [3:0]  current_req_tag;
  logic [3:0]  mem_data_tag;
  logic [63:0] mem_data;
  logic        fill_valid;
  logic [28:0] fill_addr;
  logic [63:0] fill_data;
  logic [2:0]  occupancy;

  typedef struct packed {
    logic        cmd;
    logic [28:0] addr;
    logic [63:0] data;
  } req_t;

  typedef struct packed {
    logic [28:0] addr;
    logic [63:0] data;
  } fill_t;

  req_t  exp_req[$];
  fill_t exp_fill[$];
  int    checks = 0;
  int    errors = 0;

  dcache_mshr u_dut (
    .clock            (clock),
    .reset            (reset),
    .miss_valid       (miss_valid),
    .miss_cmd         (miss_cmd),
    .miss_addr        (miss_addr),
    .miss_data        (miss_data),
    .miss_ready       (miss_ready),
    .mem_req_valid    (mem_req_valid),
    .mem_req_cmd      (mem_req_cmd),
    .mem_req_addr     (mem_req_addr),
    .mem_req_data     (mem_req_data),
    .mem_req_accepted (mem_req_accepted),
    .current_req_tag  (current_req_tag),
    .mem_data_tag     (mem_data_tag),
    .mem_data         (mem_data),
    .fill_valid       (fill_valid),
    .fill_addr        (fill_addr),
    .fill_data        (fill_data),
    .occupancy        (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Scoreboard: memory requests popped on handshake, fills popped when presented
  always @(negedge clock) begin
    if (reset && mem_req_valid && mem_req_accepted) begin
      checks++;
      if (exp_req.size() == 0) begin
        errors++;
        $display("FAIL req_unexpected: got cmd=%0d addr=%h, expected none", mem_req_cmd, mem_req_addr);
      end else begin
        req_t r;
        r = exp_req.pop_front();
        if (mem_req_cmd !== r.cmd || mem_req_addr !== r.addr ||
            (r.cmd && mem_req_data !== r.data)) begin
          errors++;
          $display("FAIL req_order: got cmd=%0d addr=%h data=%h, expected cmd=%0d addr=%h data=%h",
                   mem_req_cmd, mem_req_addr, mem_req_data, r.cmd, r.addr, r.data);
        end
      end
    end
    if (reset && fill_valid) begin
      checks++;
      if (exp_fill.size() == 0) begin
        errors++;
        $display("FAIL fill_unexpected: got addr=%h data=%h, expected no fill", fill_addr, fill_data);
      end else begin
        fill_t f;
        f = exp_fill.pop_front();
        if (fill_addr !== f.addr || fill_data !== f.data) begin
          errors++;
          $display("FAIL fill_content: got addr=%h data=%h, expected addr=%h data=%h",
                   fill_addr, fill_data, f.addr, f.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_miss(input logic cmd, input logic [28:0] addr,
                            input logic [63:0] data, input bit new_req);
    miss_valid = 1'b1;
    miss_cmd   = cmd;
    miss_addr  = addr;
    miss_data  = data;
    if (new_req) exp_req.push_back({cmd, addr, data});
    step();
    miss_valid = 1'b0;
    miss_cmd   = 1'b0;
    miss_addr  = '0;
    miss_data  = '0;
  endtask

  task automatic arb_accept(input logic [3:0] tag);
    int n = 0;
    while (!mem_req_valid && n < 20) begin
      step();
      n++;
    end
    if (!mem_req_valid) begin
      checks++;
      errors++;
      $display("FAIL arb_timeout: mem_req_valid=0 after %0d cycles, expected 1", n);
    end else begin
      mem_req_accepted = 1'b1;
      current_req_tag  = tag;
      step();
      mem_req_accepted = 1'b0;
      current_req_tag  = '0;
    end
  endtask

  task automatic mem_return(input logic [3:0] tag, input logic [63:0] data);
    mem_data_tag = tag;
    mem_data     = data;
    step();
    mem_data_tag = '0;
    mem_data     = '0;
  endtask

  task automatic test_reset();
    checks++;
    if (occupancy !== 3'd0 || miss_ready !== 1'b1 || mem_req_valid !== 1'b0 || fill_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: occ=%0d ready=%0d reqv=%0d fillv=%0d, expected 0 1 0 0",
               occupancy, miss_ready, mem_req_valid, fill_valid);
    end
  endtask

  task automatic test_single_load();
    miss_valid = 1'b1;
    miss_addr  = 29'h100;
    exp_req.push_back({1'b0, 29'h100, 64'h0});
    #1;
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_bypass: mem_req_valid=%0d in accept cycle, expected 0", mem_req_valid);
    end
    step();
    miss_valid = 1'b0;
    miss_addr  = '0;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 29'h100 || occupancy !== 3'd1) begin
      errors++;
      $display("FAIL load_issue: reqv=%0d addr=%h occ=%0d, expected 1 100 1",
               mem_req_valid, mem_req_addr, occupancy);
    end
    arb_accept(4'd3);
    repeat (3) step();
    checks++;
    if (mem_req_valid !== 1'b0 || fill_valid !== 1'b0 || occupancy !== 3'd1) begin
      errors++;
      $display("FAIL load_wait: reqv=%0d fillv=%0d occ=%0d, expected 0 0 1",
               mem_req_valid, fill_valid, occupancy);
    end
    exp_fill.push_back({29'h100, 64'hDEAD});
    mem_return(4'd3, 64'hDEAD);
    checks++;
    if (fill_valid !== 1'b1 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL load_fill: fillv=%0d occ=%0d, expected 1 0", fill_valid, occupancy);
    end
    step();
    checks++;
    if (fill_valid !== 1'b0) begin
      errors++;
      $display("FAIL fill_pulse: fillv=%0d second cycle, expected 0", fill_valid);
    end
  endtask

  task automatic test_merge();
    drive_miss(1'b0, 29'h180, 64'h0, 1'b1);
    arb_accept(4'd4);
    drive_miss(1'b0, 29'h180, 64'h0, 1'b0);
    checks++;
    if (occupancy !== 3'd1 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL merge_issued: occ=%0d reqv=%0d, expected 1 0", occupancy, mem_req_valid);
    end
    drive_miss(1'b0, 29'h1C0, 64'h0, 1'b1);
    drive_miss(1'b0, 29'h1C0, 64'h0, 1'b0);
    checks++;
    if (occupancy !== 3'd2) begin
      errors++;
      $display("FAIL merge_pending: occ=%0d, expected 2", occupancy);
    end
    arb_accept(4'd8);
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL merge_single_req: reqv=%0d, expected 0", mem_req_valid);
    end
    exp_fill.push_back({29'h180, 64'h1111});
    mem_return(4'd4, 64'h1111);
    exp_fill.push_back({29'h1C0, 64'h2222});
    mem_return(4'd8, 64'h2222);
    step();
    checks++;
    if (occupancy !== 3'd0) begin
      errors++;
      $display("FAIL merge_drain: occ=%0d, expected 0", occupancy);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) drive_miss(1'b0, 29'h400 + 29'(8 * i), 64'h0, 1'b1);
    checks++;
    if (miss_ready !== 1'b0 || occupancy !== 3'd4) begin
      errors++;
      $display("FAIL full_state: ready=%0d occ=%0d, expected 0 4", miss_ready, occupancy);
    end
    for (int i = 0; i < 4; i++) arb_accept(4'(i + 1));
    exp_fill.push_back({29'h408, 64'hA2});
    mem_return(4'd2, 64'hA2);
    checks++;
    if (miss_ready !== 1'b1 || occupancy !== 3'd3 || fill_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_free_one: ready=%0d occ=%0d fillv=%0d, expected 1 3 1",
               miss_ready, occupancy, fill_valid);
    end
    drive_miss(1'b0, 29'h500, 64'h0, 1'b1);
    checks++;
    if (miss_ready !== 1'b0 || occupancy !== 3'd4) begin
      errors++;
      $display("FAIL full_realloc: ready=%0d occ=%0d, expected 0 4", miss_ready, occupancy);
    end
    arb_accept(4'd6);
    exp_fill.push_back({29'h400, 64'hA1});
    mem_return(4'd1, 64'hA1);
    exp_fill.push_back({29'h410, 64'hA3});
    mem_return(4'd3, 64'hA3);
    exp_fill.push_back({29'h418, 64'hA4});
    mem_return(4'd4, 64'hA4);
    exp_fill.push_back({29'h500, 64'hA6});
    mem_return(4'd6, 64'hA6);
    checks++;
    if (occupancy !== 3'd0) begin
      errors++;
      $display("FAIL full_drain: occ=%0d, expected 0", occupancy);
    end
  endtask

  task automatic test_store_load_order();
    drive_miss(1'b1, 29'h200, 64'hCAFE_F00D, 1'b1);
    drive_miss(1'b0, 29'h200, 64'h0, 1'b1);
    checks++;
    if (occupancy !== 3'd2) begin
      errors++;
      $display("FAIL store_load_alloc: occ=%0d, expected 2 (store never merges)", occupancy);
    end
    arb_accept(4'd0);
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_cmd !== 1'b0 || mem_req_addr !== 29'h200 ||
        occupancy !== 3'd1 || fill_valid !== 1'b0) begin
      errors++;
      $display("FAIL store_free: reqv=%0d cmd=%0d addr=%h occ=%0d fillv=%0d, expected 1 0 200 1 0",
               mem_req_valid, mem_req_cmd, mem_req_addr, occupancy, fill_valid);
    end
    arb_accept(4'd7);
    exp_fill.push_back({29'h200, 64'hBEEF});
    mem_return(4'd7, 64'hBEEF);
    checks++;
    if (fill_valid !== 1'b1 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL store_load_fill: fillv=%0d occ=%0d, expected 1 0", fill_valid, occupancy);
    end
  endtask

  task automatic test_stall_and_simultaneous();
    drive_miss(1'b0, 29'h308, 64'h0, 1'b1);
    arb_accept(4'd2);
    drive_miss(1'b0, 29'h300, 64'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_cmd !== 1'b0 || mem_req_addr !== 29'h300) begin
        errors++;
        $display("FAIL stall_stable[%0d]: reqv=%0d cmd=%0d addr=%h, expected 1 0 300",
                 i, mem_req_valid, mem_req_cmd, mem_req_addr);
      end
      step();
    end
    mem_return(4'd9, 64'h9999);
    checks++;
    if (fill_valid !== 1'b0 || occupancy !== 3'd2 || mem_req_addr !== 29'h300) begin
      errors++;
      $display("FAIL foreign_tag: fillv=%0d occ=%0d addr=%h, expected 0 2 300",
               fill_valid, occupancy, mem_req_addr);
    end
    // Allocate, issue-accept and return all land on the same edge
    exp_req.push_back({1'b0, 29'h600, 64'h0});
    exp_fill.push_back({29'h308, 64'h3308});
    miss_valid = 1'b1; miss_cmd = 1'b0; miss_addr = 29'h600;
    mem_req_accepted = 1'b1; current_req_tag = 4'd5;
    mem_data_tag = 4'd2; mem_data = 64'h3308;
    step();
    miss_valid = 1'b0; miss_addr = '0;
    mem_req_accepted = 1'b0; current_req_tag = '0;
    mem_data_tag = '0; mem_data = '0;
    checks++;
    if (fill_valid !== 1'b1 || occupancy !== 3'd2 || mem_req_valid !== 1'b1 ||
        mem_req_addr !== 29'h600) begin
      errors++;
      $display("FAIL simultaneous: fillv=%0d occ=%0d reqv=%0d addr=%h, expected 1 2 1 600",
               fill_valid, occupancy, mem_req_valid, mem_req_addr);
    end
    arb_accept(4'd10);
    exp_fill.push_back({29'h300, 64'h3300});
    mem_return(4'd5, 64'h3300);
    exp_fill.push_back({29'h600, 64'h3600});
    mem_return(4'd10, 64'h3600);
    checks++;
    if (occupancy !== 3'd0) begin
      errors++;
      $display("FAIL simultaneous_drain: occ=%0d, expected 0", occupancy);
    end
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) begin
      drive_miss(1'b0, 29'h700 + 29'(8 * i), 64'h0, 1'b1);
      arb_accept(4'(i + 5));
    end
    drive_miss(1'b0, 29'h718, 64'h0, 1'b1);
    reset = 1'b0;
    exp_req.delete();
    step();
    checks++;
    if (occupancy !== 3'd0 || mem_req_valid !== 1'b0 || miss_ready !== 1'b1 || fill_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_midop: occ=%0d reqv=%0d ready=%0d fillv=%0d, expected 0 0 1 0",
               occupancy, mem_req_valid, miss_ready, fill_valid);
    end
    reset = 1'b1;
    step();
    mem_return(4'd5, 64'h5555);
    checks++;
    if (fill_valid !== 1'b0 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL stale_return: fillv=%0d occ=%0d, expected 0 0", fill_valid, occupancy);
    end
  endtask

  initial begin
    reset            = 1'b0;
    miss_valid       = 1'b0;
    miss_cmd         = 1'b0;
    miss_addr        = '0;
    miss_data        = '0;
    mem_req_accepted = 1'b0;
    current_req_tag  = '0;
    mem_data_tag     = '0;
    mem_data         = '0;
    repeat (3) step();
    test_reset();
    reset = 1'b1;
    step();
    test_reset();
    test_single_load();
    test_merge();
    test_full();
    test_store_load_order();
    test_stall_and_simultaneous();
    test_reset_midop();
    repeat (2) step();
    checks++;
    if (exp_req.size() !== 0 || exp_fill.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: req_left=%0d fill_left=%0d, expected 0 0",
               exp_req.size(), exp_fill.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dcache_mshr.md
# dcache_mshr

Miss-status holding register controller for the data cache. Accepts load-miss refills and dirty-eviction writebacks from the D-cache, and issues them to the memory arbiter in arrival order through a valid/accepted handshake. Tracks outstanding load tags and matches returning memory data against them. Emits one registered fill write per returned block back to the D-cache line array.

## Interface
Parameters:
- DEPTH, 4: number of MSHR slots; power of two, ≥2
- BLK_ADDR_BITS, 29: block address width (32-bit byte address, 8-byte block)
- TAG_BITS, 4: memory transaction tag width; tag 0 means "none"
- DATA_BITS, 64: block data width

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- miss_valid  in  1  D-cache presents a request this cycle
- miss_cmd  in  1  0 = load refill, 1 = store (dirty writeback)
- miss_addr  in  BLK_ADDR_BITS  block address
- miss_data  in  DATA_BITS  writeback data; ignored for loads
- miss_ready  out  1  a slot is free; request accepted when miss_valid & miss_ready
- mem_req_valid  out  1  request to arbiter
- mem_req_cmd  out  1  command of oldest unissued request
- mem_req_addr  out  BLK_ADDR_BITS  address of oldest unissued request
- mem_req_data  out  DATA_BITS  data of oldest unissued request
- mem_req_accepted  in  1  arbiter accepted the presented request this cycle
- current_req_tag  in  TAG_BITS  tag assigned to the accepted load; valid with mem_req_accepted
- mem_data_tag  in  TAG_BITS  tag of returning data; 0 = no data
- mem_data  in  DATA_BITS  returning block
- fill_valid  out  1  write fill_data into cache this cycle
- fill_addr  out  BLK_ADDR_BITS  block address of the fill
- fill_data  out  DATA_BITS  filled block
- occupancy  out  $clog2(DEPTH+1)  number of valid slots

## Operation
- Each slot holds: state (FREE, PENDING, ISSUED), cmd, addr, data, and tag.
- Allocation:
  - The lowest-index FREE slot is allocated, based on start-of-cycle state.
  - The slot becomes PENDING, and its index is pushed onto the issue FIFO.
- Merge:
  - A load whose miss_addr equals the addr of any PENDING or ISSUED load slot is accepted without allocating a slot or pushing to the FIFO.
  - The existing fill serves it.
  - Stores never merge.
- miss_ready = (occupancy < DEPTH). It does not depend on miss_valid or on merge.
- Issue:
  - mem_req_valid = issue FIFO non-empty.
  - mem_req_cmd, mem_req_addr and mem_req_data come from the slot at the FIFO head.
  - On mem_req_accepted, the FIFO pops:
    - load: the slot goes ISSUED and records current_req_tag.
    - store: the slot goes FREE (no response is expected).
- Ordering: requests issue strictly in acceptance order. A store and a later load to the same address are therefore presented to memory in that order.
- Return:
  - If mem_data_tag is nonzero and equals the tag of an ISSUED slot, that slot goes FREE.
  - fill_valid, fill_addr and fill_data are registered and appear next cycle.
  - Non-matching tags belong to other requesters and are ignored.
- Simultaneous events in one cycle (allocate, issue-accept, return) are all applied.
  - occupancy is updated by the net change.
  - A slot freed this cycle is allocatable next cycle, not this cycle.
- Reset (asynchronous, any time):
  - All slots FREE, FIFO empty, all outputs 0, miss_ready 1.
  - In-flight memory returns after reset are ignored.

## Timing
- Accept at edge N → mem_req_valid earliest in cycle N+1 (no same-cycle bypass).
- mem_req_* is held stable while mem_req_valid=1 and not accepted.
- Accept at edge M → the next FIFO entry is presented in cycle M+1.
- Data tag match in cycle R → fill_valid=1 in cycle R+1, for exactly one cycle per return.
- Tag matching uses registered ISSUED state only. A request accepted in cycle M can match data no earlier than cycle M+1.
- A merge that hits a slot being freed in the same cycle is still counted as a merge; the fill appears the following cycle.

## Structure
- Shared package / sys_defs:
  - MSHR_STATE enum {FREE, PENDING, ISSUED}
  - MSHR_ENTRY struct (state, cmd, addr, data, tag)
  - MEM_CMD constants
  - DCACHE_MSHR_DEPTH define
- Sub-module: idx_fifo, a circular FIFO of $clog2(DEPTH)-bit slot indices, DEPTH deep, with push/pop/empty/full and wrap-around pointers.
- Free-slot selection reuses the existing priority selector (psel_gen, one request).

## Test plan
- Reset asserted mid-operation with 3 slots ISSUED → next cycle occupancy=0, mem_req_valid=0, miss_ready=1; a later return with tag 5 produces no fill.
- Load miss addr 0x100 accepted cycle 0 → mem_req_valid=1, addr 0x100 in cycle 1; accepted with tag 3; mem_data_tag=3, data 0xDEAD in cycle 6 → fill_valid=1, fill_addr 0x100, fill_data 0xDEAD in cycle 7; occupancy back to 0.
- Second load to 0x100 while first is ISSUED → accepted, occupancy unchanged, no second mem request, single fill.
- Four loads fill DEPTH=4 → miss_ready=0; a return frees one slot → miss_ready=1 the next cycle; the new load is allocated to the freed slot.
- Store 0x200 then load 0x200 → presented in that order; store slot frees on accept with no fill; load fills normally.
- Arbiter holds mem_req_accepted=0 for 5 cycles → mem_req_* stable throughout; return with foreign tag 9 → no fill, no state change.
